// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares one character-RAM port between display reads, a clear sweep and buffered keyboard writes.
// Define TEXT_RAM_ARB_STARVE_GUARD_EN to let a starved write preempt reads after STARVE_MAX cycles.
module text_ram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int BLANK_CODE = 0,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state_q, state_d;
    logic              buf_v_q, buf_v_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              rd_valid_q, clr_done_q, clr_done_d;
    logic              wr_force, rd_go, clr_go, wr_go, last;
`ifdef TEXT_RAM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_q, starve_d;
    assign wr_force = buf_v_q && (starve_q >= 8'(STARVE_MAX));
    assign starve_d = (!buf_v_q || wr_go) ? 8'd0 : rd_go ? starve_q + 8'd1 : starve_q;
    always_ff @(posedge clk)
        starve_q <= rst ? 8'd0 : starve_d;
`else
    assign wr_force = 1'b0;
`endif
    // Grants are masked by rst so every RAM-side output is quiet while reset is held.
    assign rd_go     = !rst && rd_req && !wr_force;
    assign clr_go    = !rst && state_q == CLEAR && !rd_go;
    assign wr_go     = !rst && state_q == IDLE && buf_v_q && !rd_go;
    assign last      = sweep_q == ADDR_W'(DEPTH - 1);
    assign ram_addr  = rd_go ? rd_addr : clr_go ? sweep_q : wr_go ? buf_addr_q : '0;
    assign ram_we    = clr_go || wr_go;
    assign ram_wdata = clr_go ? DATA_W'(BLANK_CODE) : wr_go ? buf_data_q : '0;
    assign rd_valid  = rd_valid_q && !rst;
    assign rd_data   = rd_valid ? ram_rdata : '0;
    assign wr_ready  = !rst && !buf_v_q && state_q == IDLE;
    assign clr_busy  = !rst && state_q == CLEAR;
    assign clr_done  = clr_done_q && !rst;
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        clr_done_d = 1'b0;
        buf_v_d    = buf_v_q && !wr_go;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (wr_req && wr_ready) begin
            buf_v_d    = 1'b1;
            buf_addr_d = wr_addr;
            buf_data_d = wr_data;
        end
        if (state_q == IDLE && clr_req) begin
            state_d = CLEAR;
            buf_v_d = 1'b0;
        end
        if (clr_go) begin
            sweep_d    = last ? '0 : sweep_q + 1'b1;
            state_d    = last ? IDLE : state_q;
            clr_done_d = last;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_v_q    <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            sweep_q    <= '0;
            rd_valid_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_v_q    <= buf_v_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            sweep_q    <= sweep_d;
            rd_valid_q <= rd_go;
            clr_done_q <= clr_done_d;
        end
    end
endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb_text_ram_arbiter: directed bench with a RAM model and a read-data scoreboard, DEPTH=8.
module tb_text_ram_arbiter;
    logic       clk = 0, rst = 1;
    logic       rd_req = 0, wr_req = 0, clr_req = 0;
    logic [9:0] rd_addr = 0, wr_addr = 0, wr_data = 0;
    logic       rd_valid, wr_ready, clr_busy, clr_done, ram_we;
    logic [9:0] rd_data, ram_addr, ram_wdata, ram_rdata;
    logic [9:0] mem [0:1023];
    logic [9:0] rq [$];
    int         checks = 0, errors = 0, dcnt = 0, sw;
    int         wcnt [0:7];

    text_ram_arbiter #(.ADDR_W(10), .DATA_W(10), .DEPTH(8), .BLANK_CODE(0), .STARVE_MAX(15)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [9:0] exp;
        exp = 'x;
        if (ram_we && ram_addr < 8) wcnt[ram_addr] += 1;
        if (clr_done) dcnt++;
        if (rd_valid) begin
            if (rq.size() > 0) exp = rq.pop_front();
            chk("rd_data_sb", rd_data, exp);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 10'(i * 3 + 1);
        mem[5] = 10'h041;
        for (int k = 0; k < 8; k++) wcnt[k] = 0;
        rd_req = 1; rd_addr = 10'h005;
        @(negedge clk);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        // plain read
        nxt; rst = 0;
        @(negedge clk);
        chk("rd_addr", ram_addr, 10'h005);
        chk("rd_we", ram_we, 0);
        rq.push_back(10'h041);
        nxt; rd_req = 0;
        @(negedge clk);
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, 10'h041);
        chk("rd_we2", ram_we, 0);
        // write with idle read
        nxt; wr_req = 1; wr_addr = 10'h010; wr_data = 10'h123;
        @(negedge clk);
        chk("wr_ready0", wr_ready, 1);
        nxt; wr_req = 0;
        @(negedge clk);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 10'h010);
        chk("wr_wdata", ram_wdata, 10'h123);
        chk("wr_ready1", wr_ready, 0);
        nxt;
        @(negedge clk);
        chk("wr_ready2", wr_ready, 1);
        chk("wr_we_off", ram_we, 0);
        nxt; rd_req = 1; rd_addr = 10'h010;
        rq.push_back(10'h123);
        nxt; rd_req = 0;
        // starvation
        nxt; rd_req = 1; rd_addr = 10'h005; wr_req = 1; wr_addr = 10'h020; wr_data = 10'h2AA;
        @(negedge clk);
        chk("st_acc", wr_ready, 1);
        chk("st_we0", ram_we, 0);
        rq.push_back(10'h041);
        for (int i = 1; i <= 20; i++) begin
            nxt; wr_req = 0;
            @(negedge clk);
`ifdef TEXT_RAM_ARB_STARVE_GUARD_EN
            if (i == 16) begin
                chk("st_force_we", ram_we, 1);
                chk("st_force_addr", ram_addr, 10'h020);
                chk("st_force_data", ram_wdata, 10'h2AA);
            end else begin
                chk("st_we", ram_we, 0);
                rq.push_back(10'h041);
            end
            if (i == 17) chk("st_gap", rd_valid, 0);
`else
            chk("st_we", ram_we, 0);
            rq.push_back(10'h041);
`endif
        end
        nxt; rd_req = 0;
        @(negedge clk);
`ifdef TEXT_RAM_ARB_STARVE_GUARD_EN
        chk("st_after_we", ram_we, 0);
`else
        chk("st_late_we", ram_we, 1);
        chk("st_late_addr", ram_addr, 10'h020);
        chk("st_late_data", ram_wdata, 10'h2AA);
`endif
        nxt;
        @(negedge clk);
        chk("st_ready", wr_ready, 1);
        nxt; rd_req = 1; rd_addr = 10'h020;
        rq.push_back(10'h2AA);
        nxt; rd_req = 0;
        // clear with alternating reads and a discarded pending write
        nxt; rd_req = 1; rd_addr = 10'h100; wr_req = 1; wr_addr = 10'h030; wr_data = 10'h155;
        for (int k = 0; k < 8; k++) wcnt[k] = 0;
        dcnt = 0;
        @(negedge clk);
        rq.push_back(10'h301);
        nxt; wr_req = 0; clr_req = 1;
        @(negedge clk);
        rq.push_back(10'h301);
        chk("cl_pre_we", ram_we, 0);
        sw = 0;
        for (int j = 0; j < 40 && sw < 8; j++) begin
            nxt; clr_req = (j == 3); rd_req = (j % 2 == 1);
            @(negedge clk);
            chk("cl_busy", clr_busy, 1);
            if (rd_req) begin
                chk("cl_rd_we", ram_we, 0);
                rq.push_back(10'h301);
            end else begin
                chk("cl_we", ram_we, 1);
                chk("cl_addr", ram_addr, sw);
                chk("cl_data", ram_wdata, 0);
                sw++;
            end
        end
        chk("cl_sweep_len", sw, 8);
        nxt; rd_req = 0; clr_req = 0;
        @(negedge clk);
        chk("cl_done", clr_done, 1);
        chk("cl_busy_off", clr_busy, 0);
        chk("cl_ready", wr_ready, 1);
        nxt;
        @(negedge clk);
        chk("cl_done_pulse", clr_done, 0);
        chk("cl_no_commit", ram_we, 0);
        for (int k = 0; k < 8; k++) begin
            chk("cl_wcnt", wcnt[k], 1);
            chk("cl_blank", mem[k], 0);
        end
        chk("cl_discard", mem[10'h030], 10'h091);
        chk("cl_done_cnt", dcnt, 1);
        // reset in the middle of a sweep
        nxt;
        for (int k = 0; k < 8; k++) mem[k] = 10'h3FF;
        dcnt = 0; clr_req = 1;
        @(negedge clk);
        chk("rc_idle", clr_busy, 0);
        for (int k = 0; k < 3; k++) begin
            nxt; clr_req = 0;
            @(negedge clk);
            chk("rc_addr", ram_addr, k);
            chk("rc_we", ram_we, 1);
        end
        nxt; rst = 1;
        @(negedge clk);
        chk("rc_rst_we", ram_we, 0);
        chk("rc_rst_addr", ram_addr, 0);
        nxt; rst = 0;
        @(negedge clk);
        chk("rc_busy", clr_busy, 0);
        chk("rc_done", clr_done, 0);
        chk("rc_kept0", mem[0], 0);
        chk("rc_kept2", mem[2], 0);
        chk("rc_untouched3", mem[3], 10'h3FF);
        nxt; clr_req = 1;
        nxt; clr_req = 0;
        @(negedge clk);
        chk("rc_restart_addr", ram_addr, 0);
        chk("rc_restart_we", ram_we, 1);
        for (int k = 1; k < 10; k++) nxt;
        @(negedge clk);
        chk("rc_done_cnt", dcnt, 1);
        chk("rc_blank3", mem[3], 0);
        chk("rc_blank7", mem[7], 0);
        nxt;
        @(negedge clk);
        chk("sb_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
